// File: rtl/pulse_gen_pkg.sv
// Shared types for the programmable pulse generator: operating modes,
// per-channel FSM states and the default counter width.
package pulse_gen_pkg;

    localparam int DEFAULT_CNT_W = 16;

    typedef enum logic [1:0] {
        MODE_ONESHOT = 2'b00,
        MODE_BURST   = 2'b01,
        MODE_CONT    = 2'b10,
        MODE_GATED   = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_DELAY = 2'b01,
        ST_HIGH  = 2'b10,
        ST_LOW   = 2'b11
    } state_e;

endpackage

// File: rtl/pulse_gen_channel.sv
// One pulse channel: start edge detect, config capture, DELAY/HIGH/LOW
// down-counters and the GATED-mode consecutive-high counter.
module pulse_gen_channel
    import pulse_gen_pkg::*;
#(
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic [1:0]       mode,
    input  logic [CNT_W-1:0] delay_cfg,
    input  logic [CNT_W-1:0] width_cfg,
    input  logic [CNT_W-1:0] period_cfg,
    input  logic [CNT_W-1:0] count_cfg,
    output logic             pulse,
    output logic             busy,
    output logic             done
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    function automatic logic [CNT_W-1:0] at_least_one(input logic [CNT_W-1:0] v);
        return (v == '0) ? ONE : v;
    endfunction

    state_e           state, state_n;
    mode_e            mode_q, mode_n, mode_in;
    logic [CNT_W-1:0] delay_q, delay_n, high_q, high_n, low_q, low_n;
    logic [CNT_W-1:0] cnt, cnt_n, pulses_left, pulses_left_n, gate_cnt, gate_cnt_n;
    logic [CNT_W-1:0] width_clamped, low_len, gate_left;
    logic             launch_q, launch_n, start_low_q, capture, done_n, rise;

    assign mode_in       = mode_e'(mode);
    assign width_clamped = at_least_one(width_cfg);
    // Compare before subtracting so a short period never underflows.
    assign low_len       = (period_cfg > width_clamped) ? (period_cfg - width_clamped) : ONE;
    assign gate_left     = (gate_cnt == '0) ? at_least_one(period_cfg) : gate_cnt;
    // start_low_q resets to 0, so a start held through reset must drop first.
    assign rise          = start & start_low_q;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves a latch.
        state_n       = state;
        cnt_n         = cnt;
        pulses_left_n = pulses_left;
        gate_cnt_n    = gate_cnt;
        launch_n      = 1'b0;
        capture       = 1'b0;
        done_n        = 1'b0;

        if (stop) begin
            state_n       = ST_IDLE;
            cnt_n         = '0;
            pulses_left_n = '0;
            gate_cnt_n    = '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (launch_q) begin
                        gate_cnt_n = '0;
                        if (delay_q == '0) begin
                            state_n = ST_HIGH;
                            cnt_n   = high_q - ONE;
                        end else begin
                            state_n = ST_DELAY;
                            cnt_n   = delay_q - ONE;
                        end
                    end else if (mode_in == MODE_GATED) begin
                        if (!start) begin
                            gate_cnt_n = '0;
                        end else if (gate_left == ONE) begin
                            capture       = 1'b1;
                            state_n       = ST_HIGH;
                            cnt_n         = width_clamped - ONE;
                            pulses_left_n = '0;
                            gate_cnt_n    = '0;
                        end else begin
                            gate_cnt_n = gate_left - ONE;
                        end
                    end else begin
                        gate_cnt_n = '0;
                        if (rise) begin
                            capture       = 1'b1;
                            launch_n      = 1'b1;
                            pulses_left_n = (mode_in == MODE_BURST) ? at_least_one(count_cfg) - ONE : '0;
                        end
                    end
                end
                ST_DELAY, ST_LOW: begin
                    if (cnt != '0) begin
                        cnt_n = cnt - ONE;
                    end else begin
                        state_n = ST_HIGH;
                        cnt_n   = high_q - ONE;
                    end
                end
                ST_HIGH: begin
                    if (cnt != '0) begin
                        cnt_n = cnt - ONE;
                    end else if (mode_q != MODE_CONT && pulses_left == '0) begin
                        state_n = ST_IDLE;
                        done_n  = 1'b1;
                    end else begin
                        state_n = ST_LOW;
                        cnt_n   = low_q - ONE;
                        if (mode_q != MODE_CONT) pulses_left_n = pulses_left - ONE;
                    end
                end
                default: state_n = ST_IDLE;
            endcase
        end

        mode_n  = capture ? mode_in       : mode_q;
        delay_n = capture ? delay_cfg     : delay_q;
        high_n  = capture ? width_clamped : high_q;
        low_n   = capture ? low_len       : low_q;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            mode_q      <= MODE_ONESHOT;
            delay_q     <= '0;
            high_q      <= '0;
            low_q       <= '0;
            cnt         <= '0;
            pulses_left <= '0;
            gate_cnt    <= '0;
            launch_q    <= 1'b0;
            start_low_q <= 1'b0;
            pulse       <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_n;
            mode_q      <= mode_n;
            delay_q     <= delay_n;
            high_q      <= high_n;
            low_q       <= low_n;
            cnt         <= cnt_n;
            pulses_left <= pulses_left_n;
            gate_cnt    <= gate_cnt_n;
            launch_q    <= launch_n;
            start_low_q <= ~start;
            pulse       <= (state_n == ST_HIGH);
            busy        <= (state_n != ST_IDLE);
            done        <= done_n;
        end
    end

endmodule

// File: rtl/programmable_pulse_generator.sv
// Multi-channel programmable pulse generator: NUM_CH independent channels
// sharing one set of mode/timing configuration inputs.
module programmable_pulse_generator
    import pulse_gen_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = DEFAULT_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] start,
    input  logic [NUM_CH-1:0] stop,
    input  logic [1:0]        mode,
    input  logic [CNT_W-1:0]  delay_cfg,
    input  logic [CNT_W-1:0]  width_cfg,
    input  logic [CNT_W-1:0]  period_cfg,
    input  logic [CNT_W-1:0]  count_cfg,
    output logic [NUM_CH-1:0] pulse,
    output logic [NUM_CH-1:0] busy,
    output logic [NUM_CH-1:0] done
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        pulse_gen_channel #(
            .CNT_W(CNT_W)
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .start      (start[i]),
            .stop       (stop[i]),
            .mode       (mode),
            .delay_cfg  (delay_cfg),
            .width_cfg  (width_cfg),
            .period_cfg (period_cfg),
            .count_cfg  (count_cfg),
            .pulse      (pulse[i]),
            .busy       (busy[i]),
            .done       (done[i])
        );
    end

endmodule

// File: tb/tb_programmable_pulse_generator.sv
// Directed bench: each window plans per-edge stimulus and the expected
// pulse/busy/done trace derived from the timing formulas, then replays it.
module tb_programmable_pulse_generator;
    import pulse_gen_pkg::*;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 16;
    localparam int MAXE   = 64;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NUM_CH-1:0] start = '0;
    logic [NUM_CH-1:0] stop = '0;
    logic [1:0]        mode = MODE_ONESHOT;
    logic [CNT_W-1:0]  delay_cfg = '0;
    logic [CNT_W-1:0]  width_cfg = '0;
    logic [CNT_W-1:0]  period_cfg = '0;
    logic [CNT_W-1:0]  count_cfg = '0;
    logic [NUM_CH-1:0] pulse, busy, done;

    always #5 clk = ~clk;

    programmable_pulse_generator #(
        .NUM_CH(NUM_CH),
        .CNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .mode       (mode),
        .delay_cfg  (delay_cfg),
        .width_cfg  (width_cfg),
        .period_cfg (period_cfg),
        .count_cfg  (count_cfg),
        .pulse      (pulse),
        .busy       (busy),
        .done       (done)
    );

    typedef struct {
        string             tag;
        logic [NUM_CH-1:0] mask;
        logic [NUM_CH-1:0] pulse;
        logic [NUM_CH-1:0] busy;
        logic [NUM_CH-1:0] done;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passed = 0;
    int   failed = 0;

    // Per-edge stimulus and expectation for the current window.
    int                win_len;
    logic [NUM_CH-1:0] win_mask;
    logic              s_rst   [MAXE];
    logic [NUM_CH-1:0] s_start [MAXE];
    logic [NUM_CH-1:0] s_stop  [MAXE];
    logic [1:0]        s_mode  [MAXE];
    logic [CNT_W-1:0]  s_delay [MAXE];
    logic [CNT_W-1:0]  s_width [MAXE];
    logic [CNT_W-1:0]  s_period[MAXE];
    logic [CNT_W-1:0]  s_count [MAXE];
    logic [NUM_CH-1:0] x_pulse [MAXE];
    logic [NUM_CH-1:0] x_busy  [MAXE];
    logic [NUM_CH-1:0] x_done  [MAXE];

    task automatic check(input exp_t x);
        checks++;
        assert ((pulse & x.mask) === (x.pulse & x.mask)) passed++;
        else begin
            failed++;
            $error("FAIL %s pulse: observed %b expected %b", x.tag, pulse & x.mask, x.pulse & x.mask);
        end
        checks++;
        assert ((busy & x.mask) === (x.busy & x.mask)) passed++;
        else begin
            failed++;
            $error("FAIL %s busy: observed %b expected %b", x.tag, busy & x.mask, x.busy & x.mask);
        end
        checks++;
        assert ((done & x.mask) === (x.done & x.mask)) passed++;
        else begin
            failed++;
            $error("FAIL %s done: observed %b expected %b", x.tag, done & x.mask, x.done & x.mask);
        end
    endtask

    task automatic new_window(input int n, input logic [NUM_CH-1:0] m);
        win_len  = n;
        win_mask = m;
        for (int e = 0; e < MAXE; e++) begin
            s_rst[e]    = 1'b0;
            s_start[e]  = '0;
            s_stop[e]   = '0;
            s_mode[e]   = MODE_ONESHOT;
            s_delay[e]  = '0;
            s_width[e]  = '0;
            s_period[e] = '0;
            s_count[e]  = '0;
            x_pulse[e]  = '0;
            x_busy[e]   = '0;
            x_done[e]   = '0;
        end
    endtask

    task automatic cfg_from(input int e0, input mode_e m, input int d, input int w, input int p, input int c);
        for (int e = e0; e < MAXE; e++) begin
            s_mode[e]   = m;
            s_delay[e]  = CNT_W'(d);
            s_width[e]  = CNT_W'(w);
            s_period[e] = CNT_W'(p);
            s_count[e]  = CNT_W'(c);
        end
    endtask

    task automatic start_at(input int ch, input int e0, input int e1);
        for (int e = e0; e <= e1; e++) s_start[e][ch] = 1'b1;
    endtask

    // Expected trace for a channel launched at edge k: pulse first high after
    // edge k+1+d, W high / L low per period, done at the final fall. An abort
    // at edge s (stop or rst) truncates everything from s on and cancels done.
    task automatic plan(input int ch, input int k, input int d, input int w, input int p,
                        input int c, input bit cont, input int s);
        int wi, li, n, fall, off;
        wi   = (w < 1) ? 1 : w;
        li   = (p - wi < 1) ? 1 : p - wi;
        n    = cont ? 1000 : ((c < 1) ? 1 : c);
        fall = k + 1 + d + (n - 1) * (wi + li) + wi;
        for (int e = k + 1; e < fall && e < MAXE; e++) begin
            if (s >= 0 && e >= s) break;
            x_busy[e][ch] = 1'b1;
            off = e - (k + 1 + d);
            if (off >= 0 && (off % (wi + li)) < wi) x_pulse[e][ch] = 1'b1;
        end
        if (!(s >= 0 && s <= fall) && fall < MAXE) x_done[fall][ch] = 1'b1;
    endtask

    task automatic run_window(input string name);
        exp_t x;
        for (int e = 0; e < win_len; e++) begin
            rst        = s_rst[e];
            start      = s_start[e];
            stop       = s_stop[e];
            mode       = s_mode[e];
            delay_cfg  = s_delay[e];
            width_cfg  = s_width[e];
            period_cfg = s_period[e];
            count_cfg  = s_count[e];
            x.tag   = $sformatf("%s@%0d", name, e);
            x.mask  = win_mask;
            x.pulse = x_pulse[e];
            x.busy  = x_busy[e];
            x.done  = x_done[e];
            sb.push_back(x);
            @(posedge clk);
            #1;
            x = sb.pop_front();
            check(x);
        end
    endtask

    initial begin
        // Reset state, with start held high through rst release: no launch.
        new_window(10, 4'hF);
        cfg_from(0, MODE_ONESHOT, 0, 1, 2, 1);
        for (int e = 0; e < 3; e++) s_rst[e] = 1'b1;
        for (int e = 0; e < 10; e++) s_start[e] = 4'hF;
        run_window("reset_hold");

        // ONESHOT delay 3 width 2, launch at edge 10; re-trigger while busy ignored.
        new_window(20, 4'b0001);
        cfg_from(0, MODE_ONESHOT, 3, 2, 7, 5);
        start_at(0, 10, 11);
        start_at(0, 13, 14);
        plan(0, 10, 3, 2, 7, 1, 1'b0, -1);
        run_window("oneshot");

        // BURST delay 0 width 2 period 5 count 3.
        new_window(20, 4'b0001);
        cfg_from(0, MODE_BURST, 0, 2, 5, 3);
        start_at(0, 2, 4);
        plan(0, 2, 0, 2, 5, 3, 1'b0, -1);
        run_window("burst");

        // CONT width 1 period 4, stop on the 11th pulse edge.
        new_window(48, 4'b0001);
        cfg_from(0, MODE_CONT, 0, 1, 4, 0);
        start_at(0, 2, 2);
        s_stop[43][0] = 1'b1;
        plan(0, 2, 0, 1, 4, 0, 1'b1, 43);
        run_window("cont_stop");

        // GATED period 10 width 1: 9 high, 1 low, 12 high.
        new_window(28, 4'b0001);
        cfg_from(0, MODE_GATED, 5, 1, 10, 3);
        start_at(0, 2, 10);
        start_at(0, 12, 23);
        plan(0, 20, 0, 1, 10, 1, 1'b0, -1);
        run_window("gated");

        // width 0 and count 0 both behave as 1.
        new_window(10, 4'b0001);
        cfg_from(0, MODE_BURST, 1, 0, 3, 0);
        start_at(0, 2, 2);
        plan(0, 2, 1, 0, 3, 0, 1'b0, -1);
        run_window("zero_clamp");

        // width 6 over period 4: 6 high, 1 low.
        new_window(20, 4'b0001);
        cfg_from(0, MODE_BURST, 0, 6, 4, 2);
        start_at(0, 2, 2);
        plan(0, 2, 0, 6, 4, 2, 1'b0, -1);
        run_window("wide");

        // rst in the middle of HIGH drops pulse at that edge, no done.
        new_window(12, 4'b0001);
        cfg_from(0, MODE_ONESHOT, 0, 5, 6, 1);
        start_at(0, 2, 2);
        s_rst[5] = 1'b1;
        plan(0, 2, 0, 5, 6, 1, 1'b0, 5);
        run_window("rst_mid");

        // start+stop together: no launch; then stop during DELAY; stop while idle.
        new_window(14, 4'b0001);
        cfg_from(0, MODE_CONT, 4, 1, 2, 0);
        start_at(0, 2, 2);
        s_stop[2][0] = 1'b1;
        start_at(0, 5, 6);
        s_stop[8][0] = 1'b1;
        s_stop[11][0] = 1'b1;
        plan(0, 5, 4, 1, 2, 0, 1'b1, 8);
        run_window("stop_cases");

        // Independence: ch0 CONT with cfg A, ch3 BURST with cfg B, stop ch0 only.
        new_window(22, 4'b1001);
        cfg_from(0, MODE_CONT, 1, 2, 5, 0);
        cfg_from(4, MODE_BURST, 0, 1, 3, 4);
        start_at(0, 2, 2);
        start_at(0, 5, 6);
        start_at(3, 5, 6);
        s_stop[14][0] = 1'b1;
        plan(0, 2, 1, 2, 5, 0, 1'b1, 14);
        plan(3, 5, 0, 1, 3, 4, 1'b0, -1);
        run_window("indep");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
